div_ctrl: RTL and testbench

// - EX-stage sequencer for the multi-cycle divider. Decodes DIV/DIVU issued in EX and drives the divider's start/annul/signed/operand inputs.
// - Stalls the pipeline while the division runs. Captures the divider's 64-bit {remainder, quotient} result and presents it as a HI/LO write to the EX output mux.
// - Handles flush (annul) and returns the divider to its free state before the next issue.

---
 rtl/div_ctrl.sv | 145 ++++++++++++++
 tb/tb_div_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// EX-stage sequencer for the multi-cycle divider: issue, stall, capture HI/LO, annul, drain.
// Optional build macro DIV_ZERO_TRAP_EN traps divide-by-zero in IDLE and adds the div_zero_o port.
module div_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_op_i,
    input  logic        div_signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stall_req_o,
    output logic        whilo_o,
`ifdef DIV_ZERO_TRAP_EN
    output logic        div_zero_o,
`endif
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   op1_q, op2_q, hi_q, lo_q;
    logic          sgn_q;
    logic          issue, capture, trap, req;

`ifdef DIV_ZERO_TRAP_EN
    assign trap = (op2_i == 32'd0);
    assign div_zero_o = !rst && (state_q == IDLE) && req && trap;
`else
    assign trap = 1'b0;
`endif

    assign req  = div_op_i && !flush_i;
    assign hi_o = hi_q;
    assign lo_o = lo_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        issue        = 1'b0;
        capture      = 1'b0;
        div_start_o  = 1'b0;
        div_annul_o  = 1'b0;
        stall_req_o  = 1'b0;
        whilo_o      = 1'b0;
        div_op1_o    = rst ? 32'd0 : op1_q;
        div_op2_o    = rst ? 32'd0 : op2_q;
        div_signed_o = rst ? 1'b0  : sgn_q;
        // Reset is synchronous, so the outputs are gated for the reset cycle itself.
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req && !trap) begin
                        issue        = 1'b1;
                        div_start_o  = 1'b1;
                        stall_req_o  = 1'b1;
                        div_op1_o    = op1_i;
                        div_op2_o    = op2_i;
                        div_signed_o = div_signed_i;
                        state_d      = BUSY;
                    end
                end
                BUSY: begin
                    div_start_o = 1'b1;
                    stall_req_o = 1'b1;
                    if (flush_i) begin
                        // Flush wins over a same-cycle ready; the result is dropped.
                        div_start_o = 1'b0;
                        div_annul_o = 1'b1;
                        stall_req_o = 1'b0;
                        cnt_d       = CW'(DRAIN_CYCLES);
                        state_d     = DRAIN;
                    end else if (div_ready_i) begin
                        capture = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    // Start stays high so the divider keeps holding its result.
                    div_start_o = 1'b1;
                    whilo_o     = 1'b1;
                    if (flush_i) begin
                        div_start_o = 1'b0;
                        div_annul_o = 1'b1;
                        whilo_o     = 1'b0;
                        cnt_d       = CW'(DRAIN_CYCLES);
                        state_d     = DRAIN;
                    end else if (!stall_i) begin
                        cnt_d   = CW'(DRAIN_CYCLES);
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    stall_req_o = div_op_i;
                    if (cnt_q <= CW'(1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) begin
                op1_q <= op1_i;
                op2_q <= op2_i;
                sgn_q <= div_signed_i;
            end
            if (capture) begin
                hi_q <= div_result_i[63:32];
                lo_q <= div_result_i[31:0];
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl; the bench plays the divider, returning hand-computed results.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_op_i, div_signed_i, flush_i, stall_i, div_ready_i;
    logic [31:0] op1_i, op2_i;
    logic [63:0] div_result_i;
    logic        div_start_o, div_annul_o, div_signed_o, stall_req_o, whilo_o;
    logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
`ifdef DIV_ZERO_TRAP_EN
    logic        div_zero_o;
`endif

    int checks = 0;
    int errors = 0;

    div_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .div_op_i(div_op_i), .div_signed_i(div_signed_i),
        .op1_i(op1_i), .op2_i(op2_i),
        .flush_i(flush_i), .stall_i(stall_i),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
        .stall_req_o(stall_req_o), .whilo_o(whilo_o),
`ifdef DIV_ZERO_TRAP_EN
        .div_zero_o(div_zero_o),
`endif
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one division, answer after lat cycles, hold DONE for hold cycles, then drain.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input int hold,
                          input logic [63:0] res, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic nxt);
        logic ok;
        div_op_i = 1'b1; div_signed_i = sgn; op1_i = a; op2_i = b;
        #1;
        chk({tag, " issue"}, {div_start_o, stall_req_o, div_signed_o, whilo_o}, {3'b11, sgn, 1'b0});
        chk({tag, " opnd"}, {div_op1_o, div_op2_o}, {a, b});
        cyc();
        op1_i = ~a; op2_i = ~b;
        ok = 1'b1;
        for (int i = 1; i < lat; i++) begin
            #1;
            if (!(stall_req_o && div_start_o && !whilo_o) ||
                {div_op1_o, div_op2_o, div_signed_o} !== {a, b, sgn}) ok = 1'b0;
            cyc();
        end
        div_ready_i = 1'b1; div_result_i = res;
        #1;
        if (!stall_req_o || whilo_o || !div_start_o) ok = 1'b0;
        chk({tag, " busy"}, ok, 1'b1);
        cyc();
        div_ready_i = 1'b0; div_result_i = '1;
        stall_i = (hold > 0);
        for (int i = 0; i <= hold; i++) begin
            if (i == hold) stall_i = 1'b0;
            #1;
            chk({tag, " done"}, {whilo_o, stall_req_o, div_start_o, hi_o, lo_o},
                {3'b101, exp_hi, exp_lo});
            cyc();
        end
        div_op_i = nxt;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk({tag, " drain"}, {div_start_o, whilo_o, div_annul_o, stall_req_o, hi_o, lo_o},
                {3'b000, nxt, exp_hi, exp_lo});
            cyc();
        end
        #1;
        chk({tag, " idle"}, {div_start_o, stall_req_o}, {nxt, nxt});
    endtask

    initial begin
        rst = 1'b1; div_op_i = 1'b1; div_signed_i = 1'b1; op1_i = 32'd5; op2_i = 32'd3;
        flush_i = 1'b0; stall_i = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
        cyc(); cyc();
        #1;
        chk("reset", {div_start_o, div_annul_o, div_signed_o, stall_req_o, whilo_o,
                      div_op1_o, div_op2_o}, '0);
        chk("reset hilo", {hi_o, lo_o}, '0);
        div_op_i = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();

        // -7 / 2 = -3 rem -1, nominal latency
        do_div("div_neg", 1'b1, 32'hFFFF_FFF9, 32'd2, 35, 0,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 5, 0,
               {32'd2, 32'd14}, 32'd2, 32'h0000_000E, 1'b0);

        // Flush at cycle 10 together with ready: flush wins, result discarded
        div_op_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd1000; op2_i = 32'd3;
        cyc();
        for (int i = 1; i < 10; i++) cyc();
        flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = {32'hDEAD, 32'hBEEF};
        #1;
        chk("flush", {div_annul_o, div_start_o, whilo_o, stall_req_o}, 4'b1000);
        cyc();
        flush_i = 1'b0; div_ready_i = 1'b0; div_op_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("flush drain", {div_annul_o, div_start_o, whilo_o, hi_o, lo_o},
                {3'b000, 32'd2, 32'd14});
            cyc();
        end
        #1;
        chk("flush idle", {div_start_o, stall_req_o}, 2'b00);
        // -100 / 7 = -14 rem -2
        do_div("after_flush", 1'b1, 32'hFFFF_FF9C, 32'd7, 6, 0,
               {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

        // DONE held by downstream stall for 3 cycles
        do_div("stall", 1'b0, 32'hFFFF_FFFF, 32'h10, 4, 3,
               {32'h0000_000F, 32'h0FFF_FFFF}, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

        // Back-to-back: 50 / -5 = -10 rem 0, then 7 / 2 = 3 rem 1
        do_div("b2b_1", 1'b1, 32'd50, 32'hFFFF_FFFB, 4, 0,
               {32'd0, 32'hFFFF_FFF6}, 32'd0, 32'hFFFF_FFF6, 1'b1);
        do_div("b2b_2", 1'b1, 32'd7, 32'd2, 4, 0,
               {32'd1, 32'd3}, 32'd1, 32'd3, 1'b0);

        // Flush in IDLE blocks issue
        div_op_i = 1'b1; flush_i = 1'b1; op1_i = 32'd9; op2_i = 32'd3;
        #1;
        chk("idle flush", {div_start_o, stall_req_o}, 2'b00);
        cyc();
        flush_i = 1'b0; div_op_i = 1'b0;
        #1;
        chk("idle flush after", {div_start_o, stall_req_o, div_annul_o}, 3'b000);

        // Divide by zero
`ifdef DIV_ZERO_TRAP_EN
        div_op_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd9; op2_i = 32'd0;
        #1;
        chk("dz trap", {div_zero_o, div_start_o, stall_req_o, whilo_o}, 4'b1000);
        cyc();
        div_op_i = 1'b0;
        #1;
        chk("dz after", {div_zero_o, div_start_o, hi_o, lo_o}, {2'b00, 32'd1, 32'd3});
`else
        do_div("dz", 1'b0, 32'd9, 32'd0, 4, 0, 64'd0, 32'd0, 32'd0, 1'b0);
`endif

        // Reset mid-operation
        div_op_i = 1'b1; div_signed_i = 1'b0; op1_i = 32'd8; op2_i = 32'd2;
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("rst mid", {div_start_o, stall_req_o, div_annul_o, whilo_o}, 4'b0000);
        cyc();
        rst = 1'b0; div_op_i = 1'b0;
        #1;
        chk("rst after", {div_start_o, stall_req_o, whilo_o, hi_o, lo_o}, '0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
